uart_rx_frame_ctrl: RTL
=======================

Name: uart_rx_frame_ctrl

Overview:
- Receive-side frame controller for the UART RX. It sits between the serial line and the parallel output, and closes the loop with the edge/bit counter.
- Drives the counter enable and consumes the counter's edge_cnt/bit_cnt.
- Majority-samples each bit, then runs the start/data/parity/stop state machine.
- Outputs a parallel byte with a one-cycle valid pulse, plus parity and stop error flags.

Parameters:
DATA_WIDTH, 8, payload bits per frame; legal 5..8 (bit_cnt is 4 bits).

Ports:
clk  input  1  system clock (oversampled bit clock domain)
rst  input  1  synchronous, active-high reset
rx_in  input  1  serial line, already synchronized; idle high
prescale  input  6  oversampling ratio; legal even values 8..32; stable for the whole frame
par_en  input  1  1 = frame carries a parity bit
par_typ  input  1  0 = even, 1 = odd parity
edge_cnt  input  6  counter edge count; runs 1..prescale; held at 1 when the counter is disabled
bit_cnt  input  4  counter bit index; increments when edge_cnt==prescale; held at 0 when disabled
edge_bit_cnt_en  output  1  counter enable
p_data  output  DATA_WIDTH  last good received word, LSB first on line
data_valid  output  1  one-cycle pulse: p_data updated
par_err  output  1  one-cycle pulse: parity mismatch
stp_err  output  1  one-cycle pulse: stop bit sampled low
rx_busy  output  1  high while a frame is in progress

Behaviour:
- Reset: rst high at a clk edge puts the FSM in IDLE. All outputs and internal registers clear to 0 on that edge, including p_data, and apply on the following cycle.
- Enable and busy decode: edge_bit_cnt_en = rx_busy = (state != IDLE). Both are combinational decodes of the registered state.
- Sampling points: let h = prescale>>1.
  - rx_in is captured into s0, s1, s2 on the cycles where edge_cnt == h-1, h and h+1 respectively.
  - The bit value is maj = majority(s0, s1, s2).
  - maj is consumed only in the end-of-bit cycle, defined as edge_cnt==prescale.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: if rx_in==0, go to START on the next edge and latch par_en/par_typ into frame-local copies. Otherwise stay in IDLE.
  - START (bit_cnt==0): at end-of-bit, if maj==1 the start was a glitch; go to IDLE with no output pulses. If maj==0, go to DATA.
  - DATA (bit_cnt 1..DATA_WIDTH): at each end-of-bit, write maj into shift register position bit_cnt-1 (LSB first).
    - When bit_cnt==DATA_WIDTH, go to PARITY if the latched par_en is 1, else to STOP.
  - PARITY (bit_cnt==DATA_WIDTH+1): at end-of-bit, compute expected = (XOR of shift reg) XOR latched par_typ. Store perr = (maj != expected). Go to STOP.
  - STOP (bit_cnt==DATA_WIDTH+1+par_en): at end-of-bit, serr = ~maj. Go to IDLE.
    - The counter is disabled on the next cycle, which resets it.
- Frame completion: on the clock edge that leaves STOP, the outputs update as follows:
  - data_valid <= ~perr & ~serr.
  - par_err <= perr.
  - stp_err <= serr.
  - p_data <= shift reg, only when the frame is good. On an error p_data holds its previous value.
  - All three pulses return to 0 on the following edge.
- Latency: data_valid rises exactly 1 cycle after the end-of-bit cycle of the stop bit. Total frame length is 1 + (1+DATA_WIDTH+par_en+1)*prescale cycles from the first low rx_in sample to data_valid.
- Back-to-back frames: IDLE accepts a new start bit on the first cycle after the frame completes. A start detected in that cycle is legal.
- Glitches in IDLE: a low pulse shorter than the majority window is rejected in START. The block is back in IDLE after prescale+1 cycles.
- Parameter changes: changes to par_en/par_typ mid-frame are ignored, because the latched copies are used. A prescale change mid-frame is a system error and the block's behaviour is undefined.
- Reset mid-frame: the block goes to IDLE, the enable drops, no pulses are emitted, and p_data clears to 0.
- Out-of-range counter values: a bit_cnt value not matching the current state is treated as a desync. The block goes to IDLE silently.

Test Plan:
- Good frame: prescale=8, par_en=1, par_typ=0, frame 0xA5 with correct parity bit 0 -> one data_valid pulse with p_data=0xA5, par_err=0, stp_err=0; pulse lands 1+11*8 cycles after the start edge.
- Parity error: prescale=16, par_en=1, par_typ=1, frame 0x3C with parity bit 0 -> par_err pulse, data_valid=0, p_data keeps the prior 0xA5.
- Stop error: prescale=8, par_en=0, frame 0x81 with stop bit driven 0 -> stp_err pulse only; rx_busy falls afterwards.
- Start glitch plus majority: prescale=16, rx_in low for 3 cycles -> no pulses and rx_busy low after 17 cycles. A good frame 0x55 with one inverted sample at edge h in bit 3 -> p_data=0x55.
- Back-to-back and reset: prescale=32, par_en=0, frames 0x12 then 0xFE with no idle gap -> two valid pulses with the correct data. Then rst asserted in DATA mid-frame -> edge_bit_cnt_en=0 and p_data=0 the next cycle, and no pulses.

Source files
------------

// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: received-word and frame-status bundle from the UART RX frame controller
interface uart_rx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] p_data;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  rx_busy;

    modport master (
        output p_data,
        output data_valid,
        output par_err,
        output stp_err,
        output rx_busy
    );

    modport slave (
        input p_data,
        input data_valid,
        input par_err,
        input stp_err,
        input rx_busy
    );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: oversampled UART receive framing with 3-point majority voting and parity/stop checks
module uart_rx_frame_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_in,
    input  logic [5:0]           prescale,
    input  logic                 par_en,
    input  logic                 par_typ,
    input  logic [5:0]           edge_cnt,
    input  logic [3:0]           bit_cnt,
    output logic                 edge_bit_cnt_en,
    uart_rx_frame_ctrl_if.master frame
);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] DW = 4'(DATA_WIDTH);

    state_t                state;
    logic                  s0, s1, s2;
    logic                  maj;
    logic                  eob;
    logic                  pe_l, pt_l;
    logic                  perr;
    logic                  bit_ok;
    logic [DATA_WIDTH-1:0] shreg;
    logic [5:0]            h;

    assign h               = {1'b0, prescale[5:1]};
    assign maj             = (s0 & s1) | (s0 & s2) | (s1 & s2);
    assign eob             = edge_cnt == prescale;
    assign edge_bit_cnt_en = state != IDLE;
    assign frame.rx_busy   = state != IDLE;

    // The counter's bit index must agree with the state; anything else means it lost sync.
    always_comb begin
        bit_ok = state == START  ? bit_cnt == 4'd0 :
                 state == DATA   ? (bit_cnt >= 4'd1 && bit_cnt <= DW) :
                 state == PARITY ? bit_cnt == DW + 4'd1 :
                 state == STOP   ? bit_cnt == DW + 4'd1 + {3'b0, pe_l} :
                 1'b1;
    end

    // Capture the line at the three points straddling mid-bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            s0 <= 1'b0;
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            if (edge_cnt == h - 6'd1) s0 <= rx_in;
            if (edge_cnt == h)        s1 <= rx_in;
            if (edge_cnt == h + 6'd1) s2 <= rx_in;
        end
    end

    // Frame state machine; result pulses and the output word are registered on leaving STOP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            pe_l             <= 1'b0;
            pt_l             <= 1'b0;
            perr             <= 1'b0;
            shreg            <= '0;
            frame.p_data     <= '0;
            frame.data_valid <= 1'b0;
            frame.par_err    <= 1'b0;
            frame.stp_err    <= 1'b0;
        end else begin
            frame.data_valid <= 1'b0;
            frame.par_err    <= 1'b0;
            frame.stp_err    <= 1'b0;
            if (state != IDLE && !bit_ok) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (!rx_in) begin
                            state <= START;
                            pe_l  <= par_en;
                            pt_l  <= par_typ;
                            perr  <= 1'b0;
                        end
                    end
                    START: begin
                        if (eob) state <= maj ? IDLE : DATA;
                    end
                    DATA: begin
                        if (eob) begin
                            for (int i = 0; i < DATA_WIDTH; i++)
                                if (bit_cnt == 4'(i + 1)) shreg[i] <= maj;
                            if (bit_cnt == DW) state <= pe_l ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        if (eob) begin
                            perr  <= maj != (^shreg ^ pt_l);
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        if (eob) begin
                            frame.data_valid <= ~perr & maj;
                            frame.par_err    <= perr;
                            frame.stp_err    <= ~maj;
                            if (~perr & maj) frame.p_data <= shreg;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
